// File: rtl/register_file.sv
// Two-read, one-write integer register file with write-through bypass,
// a shift-amount tap on port 2 and an unbypassed debug read port.
module register_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    input  logic              rd_wren,
    input  logic [4:0]        rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [4:0]        rs2_shamt,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_en;
    logic              byp_en;

    assign wr_en  = rd_wren && (rd_addr != 5'd0);
    assign byp_en = rst_n && wr_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rd_addr] <= rd_data;
        end
    end

    // x0 is forced to zero at the read mux; its flop is never consulted
    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (byp_en && (rs1_addr == rd_addr)) begin
            rs1_data = rd_data;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (byp_en && (rs2_addr == rd_addr)) begin
            rs2_data = rd_data;
        end
    end

    assign rs2_shamt = rs2_data[4:0];
    assign dbg_data  = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule
